btb_ctrl: RTL and testbench

//  Sequencing/ownership controller for the direct-mapped branch target buffer.

---
 rtl/btb_ctrl.sv | 135 +++++++++++++
 tb/tb_btb_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// btb_ctrl: BTB lookup/update sequencer with an update queue and per-set valid bits (optional BTB_CTRL_BYPASS_EN)
module btb_ctrl #(
   parameter int IDX_WIDTH = 6,
   parameter int QDEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   output logic        pred_hit,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic        upd_inval,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        flush,
   output logic        btb_read,
   output logic [31:0] btb_r_pc,
   output logic        btb_load,
   output logic [31:0] btb_w_pc,
   output logic [31:0] btb_target_in,
   input  logic        btb_hit,
   input  logic [31:0] btb_target_out
);
   localparam int SETS = 2 ** IDX_WIDTH;
   localparam int PW = $clog2(QDEPTH);
   typedef enum logic {IDLE, DRAIN} state_t;
   state_t state, state_next;
   logic [SETS-1:0] valid_q;
   logic q_inval [QDEPTH];
   logic [31:0] q_pc [QDEPTH];
   logic [31:0] q_tgt [QDEPTH];
   logic [PW-1:0] head, tail;
   logic [PW:0] count;
   logic full, push, collision, issue;
   logic req_q, valid_q_q, flush_q;
   assign full = count == (PW+1)'(QDEPTH);
   assign upd_ready = !full;
   assign push = upd_valid && !full && !flush;
   assign btb_read = fetch_req;
   assign btb_r_pc = fetch_pc;
   assign btb_w_pc = q_pc[head];
   assign btb_target_in = q_tgt[head];
   assign collision = fetch_req && (fetch_pc[IDX_WIDTH-1:0] == q_pc[head][IDX_WIDTH-1:0]);
   // drain FSM: issue the head unless a same-index fetch read is in flight
   always_comb begin
      state_next = state;
      issue = 1'b0;
      btb_load = 1'b0;
      if (state == DRAIN) begin
         issue = !collision && !flush;
         btb_load = issue && !q_inval[head];
      end
      if (flush) state_next = IDLE;
      else if (state == IDLE && push) state_next = DRAIN;
      else if (issue && count == (PW+1)'(1) && !push) state_next = IDLE;
   end
   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_next;
   end
   // queue pointers and occupancy; flush empties the queue and drops a same-cycle push
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (issue) head <= head + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(issue);
      end
   end
   // queue storage needs no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         q_inval[tail] <= upd_inval;
         q_pc[tail] <= upd_pc;
         q_tgt[tail] <= upd_target;
      end
   end
   // per-set valid bits; flush wins over an issue in the same cycle
   always_ff @(posedge clk) begin
      if (rst || flush) valid_q <= '0;
      else if (issue) valid_q[q_pc[head][IDX_WIDTH-1:0]] <= !q_inval[head];
   end
   // lookup pipeline stage aligned with the array's one-cycle read
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= 1'b0;
         valid_q_q <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         req_q <= fetch_req;
         valid_q_q <= valid_q[fetch_pc[IDX_WIDTH-1:0]];
         flush_q <= flush;
      end
   end
`ifdef BTB_CTRL_BYPASS_EN
   logic byp_hit, byp_wr, byp_hit_q, byp_wr_q;
   logic [31:0] byp_tgt, byp_tgt_q;
   // CAM over queued entries, scanned oldest to youngest so the youngest match wins
   always_comb begin
      byp_hit = 1'b0;
      byp_wr = 1'b0;
      byp_tgt = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if ((PW+1)'(i) < count && q_pc[head + PW'(i)] == fetch_pc) begin
            byp_hit = 1'b1;
            byp_wr = !q_inval[head + PW'(i)];
            byp_tgt = q_tgt[head + PW'(i)];
         end
      end
   end
   // register the bypass match alongside the array lookup
   always_ff @(posedge clk) begin
      if (rst) begin
         byp_hit_q <= 1'b0;
         byp_wr_q <= 1'b0;
         byp_tgt_q <= '0;
      end else begin
         byp_hit_q <= fetch_req && byp_hit;
         byp_wr_q <= byp_wr;
         byp_tgt_q <= byp_tgt;
      end
   end
   assign pred_hit = req_q && !flush_q && (byp_hit_q ? byp_wr_q : (valid_q_q && btb_hit));
   assign pred_target = byp_hit_q ? byp_tgt_q : (req_q ? btb_target_out : '0);
`else
   assign pred_hit = req_q && !flush_q && valid_q_q && btb_hit;
   assign pred_target = req_q ? btb_target_out : '0;
`endif
endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl: directed bench for btb_ctrl with a behavioural direct-mapped BTB array
module tb_btb_ctrl;
   logic clk = 1'b0;
   logic rst, fetch_req, upd_valid, upd_inval, flush, btb_hit;
   logic [31:0] fetch_pc, upd_pc, upd_target, btb_target_out;
   logic pred_hit, upd_ready, btb_read, btb_load;
   logic [31:0] pred_target, btb_r_pc, btb_w_pc, btb_target_in;
   int n_checks = 0;
   int n_fail = 0;
   logic m_v [64];
   logic [25:0] m_tag [64];
   logic [31:0] m_tgt [64];

   btb_ctrl dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .pred_hit(pred_hit), .pred_target(pred_target), .upd_valid(upd_valid),
      .upd_ready(upd_ready), .upd_inval(upd_inval), .upd_pc(upd_pc),
      .upd_target(upd_target), .flush(flush), .btb_read(btb_read),
      .btb_r_pc(btb_r_pc), .btb_load(btb_load), .btb_w_pc(btb_w_pc),
      .btb_target_in(btb_target_in), .btb_hit(btb_hit), .btb_target_out(btb_target_out)
   );

   always #5 clk = ~clk;

   // external BTB array: tag-matched, one-cycle read
   initial for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
   always @(posedge clk) begin
      if (btb_load) begin
         m_v[btb_w_pc[5:0]] <= 1'b1;
         m_tag[btb_w_pc[5:0]] <= btb_w_pc[31:6];
         m_tgt[btb_w_pc[5:0]] <= btb_target_in;
      end
      if (btb_read) begin
         btb_hit <= m_v[btb_r_pc[5:0]] && m_tag[btb_r_pc[5:0]] == btb_r_pc[31:6];
         btb_target_out <= m_tgt[btb_r_pc[5:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic eh, input logic [31:0] et);
      fetch_req = 1'b1;
      fetch_pc = pc;
      @(negedge clk);
      fetch_req = 1'b0;
      check({tag, "_hit"}, pred_hit, eh);
      if (eh) check({tag, "_tgt"}, pred_target, et);
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic inv);
      upd_valid = 1'b1;
      upd_pc = pc;
      upd_target = tgt;
      upd_inval = inv;
      @(negedge clk);
      upd_valid = 1'b0;
      upd_inval = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; upd_valid = 1'b0; upd_inval = 1'b0;
      upd_pc = '0; upd_target = '0; flush = 1'b0; btb_hit = 1'b0; btb_target_out = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pred_hit", pred_hit, 0);
      check("rst_pred_tgt", pred_target, 0);
      check("rst_load", btb_load, 0);
      check("rst_ready", upd_ready, 1);
      rst = 1'b0;
      lookup("t1_miss", 32'h100, 1'b0, 0);
      // single update: not drained in the push cycle, loaded the next
      upd_valid = 1'b1; upd_pc = 32'h104; upd_target = 32'h200;
      #1 check("t2_no_same_cycle", btb_load, 0);
      @(negedge clk);
      upd_valid = 1'b0;
      #1 check("t2_load", btb_load, 1);
      check("t2_w_pc", btb_w_pc, 32'h104);
      check("t2_w_tgt", btb_target_in, 32'h200);
      @(negedge clk);
      @(negedge clk);
      lookup("t2_lookup", 32'h104, 1'b1, 32'h200);
      // collision stall: same index fetched every cycle holds the queue
      fetch_req = 1'b1; fetch_pc = 32'h104;
      for (int i = 0; i < 4; i++) begin
         upd_valid = 1'b1; upd_pc = 32'h144; upd_target = 32'h500 + 32'(i * 16);
         #1 check("t3_held", btb_load, 0);
         check("t3_ready", upd_ready, 1);
         @(negedge clk);
      end
      upd_valid = 1'b0;
      #1 check("t3_full", upd_ready, 0);
      check("t3_held_full", btb_load, 0);
      @(negedge clk);
      check("t3_still_full", upd_ready, 0);
      fetch_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 check("t3_drain_load", btb_load, 1);
         check("t3_drain_tgt", btb_target_in, 32'h500 + 32'(i * 16));
         @(negedge clk);
      end
      #1 check("t3_drained", btb_load, 0);
      check("t3_ready_again", upd_ready, 1);
      @(negedge clk);
      lookup("t3_new", 32'h144, 1'b1, 32'h530);
      lookup("t3_old", 32'h104, 1'b0, 0);
      // write then invalidate
      push(32'h108, 32'h300, 1'b0);
      @(negedge clk);
      lookup("t4_write", 32'h108, 1'b1, 32'h300);
      upd_valid = 1'b1; upd_inval = 1'b1; upd_pc = 32'h108;
      @(negedge clk);
      upd_valid = 1'b0; upd_inval = 1'b0;
      #1 check("t4_inval_noload", btb_load, 0);
      @(negedge clk);
      lookup("t4_inval", 32'h108, 1'b0, 0);
      // flush with three queued entries and a concurrent push
      fetch_req = 1'b1; fetch_pc = 32'h110;
      for (int i = 0; i < 3; i++) push(32'h150 + 32'(i * 64), 32'h700 + 32'(i * 16), 1'b0);
      flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h110; upd_target = 32'h7F0; fetch_pc = 32'h144;
      #1 check("t5_flush_noload", btb_load, 0);
      @(negedge clk);
      flush = 1'b0; upd_valid = 1'b0; fetch_req = 1'b0;
      check("t5_flush_kill", pred_hit, 0);
      check("t5_ready", upd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         #1 check("t5_no_load", btb_load, 0);
         @(negedge clk);
      end
      lookup("t5_miss_144", 32'h144, 1'b0, 0);
      lookup("t5_miss_110", 32'h110, 1'b0, 0);
      // queued updates under a stall: visible only with the bypass
      fetch_req = 1'b1; fetch_pc = 32'h10C;
      push(32'h10C, 32'h400, 1'b0);
      push(32'h10C, 32'h480, 1'b0);
      @(negedge clk);
`ifdef BTB_CTRL_BYPASS_EN
      check("t6_byp_hit", pred_hit, 1);
      check("t6_byp_tgt", pred_target, 32'h480);
`else
      check("t6_no_byp", pred_hit, 0);
`endif
      fetch_req = 1'b0;
      repeat (3) @(negedge clk);
      lookup("t6_drained", 32'h10C, 1'b1, 32'h480);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
